// File: rtl/w0rm_alu_pkg.sv
// Shared definitions for the w0rm ALU and the arbiter in front of it:
// opcode encodings, flag bit positions, requester IDs and the in-flight tag.
package w0rm_alu_pkg;

    localparam logic [3:0] ALU_OP_AND = 4'h0;
    localparam logic [3:0] ALU_OP_OR  = 4'h1;
    localparam logic [3:0] ALU_OP_XOR = 4'h2;
    localparam logic [3:0] ALU_OP_NOT = 4'h3;
    localparam logic [3:0] ALU_OP_NEG = 4'h4;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_OVER  = 2;
    localparam int FLAG_CARRY = 3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // One in-flight ALU operation: whether the slot is occupied and who owns it.
    typedef struct packed {
        logic valid;
        logic port;
    } alu_tag_t;

endpackage

// File: rtl/w0rm_alu_tag_pipe.sv
// Shift register of {valid, port} tags that travels alongside the ALU so the
// owner of each result is known when it returns. The last stage is the head.
module w0rm_alu_tag_pipe
    import w0rm_alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  alu_tag_t in_tag,
    output alu_tag_t head_tag
);

    alu_tag_t stage [DEPTH];

    // Advance every tag one stage per cycle; reset drops all in-flight tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign head_tag = stage[DEPTH-1];

endmodule

// File: rtl/w0rm_alu_arbiter.sv
// Two-port round-robin front end for one shared W0RM_ALU_Logic instance.
// Optional performance counters are built when W0RM_ALU_ARB_PERF_EN is defined.
module w0rm_alu_arbiter
    import w0rm_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ALU_LATENCY = 1,
    parameter int PERF_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_opcode,
    input  logic [DATA_WIDTH-1:0] req0_data_a,
    input  logic [DATA_WIDTH-1:0] req0_data_b,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_opcode,
    input  logic [DATA_WIDTH-1:0] req1_data_a,
    input  logic [DATA_WIDTH-1:0] req1_data_b,

    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_result,
    output logic [3:0]            resp0_flags,

    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_result,
    output logic [3:0]            resp1_flags,

    output logic                  alu_data_valid,
    output logic [3:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_data_a,
    output logic [DATA_WIDTH-1:0] alu_data_b,

    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_result_valid,
    input  logic [3:0]            alu_result_flags
`ifdef W0RM_ALU_ARB_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_grant0,
    output logic [PERF_WIDTH-1:0] perf_grant1,
    output logic [PERF_WIDTH-1:0] perf_conflict
`endif
);

    if (DATA_WIDTH < 1 || ALU_LATENCY < 0 || PERF_WIDTH < 1) begin : g_param_check
        $error("w0rm_alu_arbiter: illegal parameter value");
    end

    logic     last_grant;
    logic     xfer0;
    logic     xfer1;
    logic     xfer_any;
    alu_tag_t issue_tag;
    alu_tag_t head_tag;

    // Round-robin grant: a lone requester always wins, a tie goes to the port
    // that was not granted last. Each ready looks only at the valids, never at
    // the other ready, so there is no combinational loop between ports.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset) begin
            req0_ready = req0_valid && (!req1_valid || last_grant == PORT1);
            req1_ready = req1_valid && (!req0_valid || last_grant == PORT0);
        end
    end

    assign xfer0    = req0_valid && req0_ready;
    assign xfer1    = req1_valid && req1_ready;
    assign xfer_any = xfer0 || xfer1;

    // Remember the most recent winner; reset to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT1;
        end else if (xfer0) begin
            last_grant <= PORT0;
        end else if (xfer1) begin
            last_grant <= PORT1;
        end
    end

    // Issue register: latch the winning operation and pulse alu_data_valid once.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_data_valid <= 1'b0;
            alu_opcode     <= '0;
            alu_data_a     <= '0;
            alu_data_b     <= '0;
        end else begin
            alu_data_valid <= xfer_any;
            if (xfer0) begin
                alu_opcode <= req0_opcode;
                alu_data_a <= req0_data_a;
                alu_data_b <= req0_data_b;
            end else if (xfer1) begin
                alu_opcode <= req1_opcode;
                alu_data_a <= req1_data_a;
                alu_data_b <= req1_data_b;
            end
        end
    end

    // Tag entering the pipe alongside the issue register contents.
    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = xfer_any;
        issue_tag.port  = xfer1 ? PORT1 : PORT0;
    end

    // Depth ALU_LATENCY+1 puts the head in the same cycle as alu_result_valid.
    w0rm_alu_tag_pipe #(
        .DEPTH (ALU_LATENCY + 1)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_tag   (issue_tag),
        .head_tag (head_tag)
    );

    // Route a returning result to its owner; a pulse with no live tag is stale and dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
            resp0_flags  <= '0;
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
            resp1_flags  <= '0;
        end else begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            if (alu_result_valid && head_tag.valid) begin
                if (head_tag.port == PORT0) begin
                    resp0_valid  <= 1'b1;
                    resp0_result <= alu_result;
                    resp0_flags  <= alu_result_flags;
                end else begin
                    resp1_valid  <= 1'b1;
                    resp1_result <= alu_result;
                    resp1_flags  <= alu_result_flags;
                end
            end
        end
    end

`ifdef W0RM_ALU_ARB_PERF_EN
    // Free-running grant and contention counters; they wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (xfer0) begin
                perf_grant0 <= perf_grant0 + 1'b1;
            end
            if (xfer1) begin
                perf_grant1 <= perf_grant1 + 1'b1;
            end
            if (req0_valid && req1_valid) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_w0rm_alu_arbiter.sv
// Scoreboard bench for w0rm_alu_arbiter with a behavioural one-cycle ALU.
module tb_w0rm_alu_arbiter;
    import w0rm_alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_opcode, req1_opcode;
    logic [7:0] req0_data_a, req0_data_b, req1_data_a, req1_data_b;
    logic       resp0_valid, resp1_valid;
    logic [7:0] resp0_result, resp1_result;
    logic [3:0] resp0_flags, resp1_flags;
    logic       alu_data_valid;
    logic [3:0] alu_opcode;
    logic [7:0] alu_data_a, alu_data_b;
    logic [7:0] alu_result = 8'h00;
    logic       alu_result_valid = 1'b0;
    logic [3:0] alu_result_flags = 4'h0;
    logic       inject_stale = 1'b0;
`ifdef W0RM_ALU_ARB_PERF_EN
    logic [15:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    w0rm_alu_arbiter #(.DATA_WIDTH(8), .ALU_LATENCY(1), .PERF_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_data_a(req0_data_a), .req0_data_b(req0_data_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_data_a(req1_data_a), .req1_data_b(req1_data_b),
        .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_flags(resp0_flags),
        .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_flags(resp1_flags),
        .alu_data_valid(alu_data_valid), .alu_opcode(alu_opcode),
        .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
        .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .alu_result_flags(alu_result_flags)
`ifdef W0RM_ALU_ARB_PERF_EN
        ,
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU, one cycle latency, no reset (may emit stale pulses).
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [3:0] f;
        case (op)
            ALU_OP_AND: r = a & b;
            ALU_OP_OR:  r = a | b;
            ALU_OP_XOR: r = a ^ b;
            ALU_OP_NOT: r = ~a;
            ALU_OP_NEG: r = 8'h00 - a;
            default:    r = 8'h00;
        endcase
        f = 4'h0;
        f[FLAG_ZERO]  = (r == 8'h00);
        f[FLAG_NEG]   = r[7];
        f[FLAG_OVER]  = 1'b0;
        f[FLAG_CARRY] = 1'b0;
        return {r, f};
    endfunction

    always @(posedge clk) begin
        alu_result_valid <= alu_data_valid | inject_stale;
        if (alu_data_valid) begin
            {alu_result, alu_result_flags} <= alu_fn(alu_opcode, alu_data_a, alu_data_b);
        end
    end

    typedef struct {
        logic        port;
        logic [11:0] rf;
        int          due;
    } exp_t;

    exp_t q[$];
    int   nchecks = 0;
    int   nerr = 0;
    int   n_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (resp0_valid && resp1_valid) check("resp_both", 32'd1, 32'd0);
        if (resp0_valid || resp1_valid) begin
            n_pulses++;
            if (q.size() == 0) begin
                check("resp_unexpected", {31'd0, resp1_valid}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("resp_port", {31'd0, resp1_valid}, {31'd0, e.port});
                if (resp0_valid) check("resp0_data", {20'd0, resp0_result, resp0_flags}, {20'd0, e.rf});
                else             check("resp1_data", {20'd0, resp1_result, resp1_flags}, {20'd0, e.rf});
                check("resp_cycle", cyc, e.due);
            end
        end
    end

    // Present one cycle of inputs, check the grant, queue the expected response.
    task automatic step(input logic v0, input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic v1, input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic [1:0] gnt, input bit push,
                        input logic [11:0] exp0, input logic [11:0] exp1);
        exp_t e;
        req0_valid = v0; req0_opcode = op0; req0_data_a = a0; req0_data_b = b0;
        req1_valid = v1; req1_opcode = op1; req1_data_a = a1; req1_data_b = b1;
        @(negedge clk);
        check("grant", {30'd0, req1_ready, req0_ready}, {30'd0, gnt});
        if (push && gnt == 2'b01) begin
            e.port = PORT0; e.rf = exp0; e.due = cyc + 3; q.push_back(e);
        end else if (push && gnt == 2'b10) begin
            e.port = PORT1; e.rf = exp1; e.due = cyc + 3; q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'h0, 8'h00, 8'h00, 0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 12'h0, 12'h0);
    endtask

    initial begin
        int p0;
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_opcode = 4'h1; req1_opcode = 4'h2;
        req0_data_a = 8'h55; req0_data_b = 8'h66; req1_data_a = 8'h77; req1_data_b = 8'h88;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("rst_issue", {15'd0, alu_data_valid, alu_opcode, alu_data_a, alu_data_b}, 32'd0);
        check("rst_resp", {6'd0, resp0_valid, resp1_valid, resp0_result, resp0_flags, resp1_result, resp1_flags}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First tie after reset: port 0 then port 1.
        step(1, ALU_OP_OR, 8'h0F, 8'hF0, 1, ALU_OP_XOR, 8'hAA, 8'hAA, 2'b01, 1, {8'hFF, 4'b0010}, {8'h00, 4'b0001});
        step(0, ALU_OP_OR, 8'h0F, 8'hF0, 1, ALU_OP_XOR, 8'hAA, 8'hAA, 2'b10, 1, {8'hFF, 4'b0010}, {8'h00, 4'b0001});
        // Single request on port 0.
        step(1, ALU_OP_AND, 8'hF0, 8'h3C, 0, 4'h0, 8'h00, 8'h00, 2'b01, 1, {8'h30, 4'b0000}, 12'h0);
        check("issue_opcode", {28'd0, alu_opcode}, {28'd0, ALU_OP_AND});
        check("issue_operands", {16'd0, alu_data_a, alu_data_b}, 32'h0000_F03C);
        // Back-to-back NOTs on port 1.
        step(0, 4'h0, 8'h00, 8'h00, 1, ALU_OP_NOT, 8'h00, 8'h00, 2'b10, 1, 12'h0, {8'hFF, 4'b0010});
        step(0, 4'h0, 8'h00, 8'h00, 1, ALU_OP_NOT, 8'h01, 8'h00, 2'b10, 1, 12'h0, {8'hFE, 4'b0010});
        step(0, 4'h0, 8'h00, 8'h00, 1, ALU_OP_NOT, 8'h02, 8'h00, 2'b10, 1, 12'h0, {8'hFD, 4'b0010});
        step(0, 4'h0, 8'h00, 8'h00, 1, ALU_OP_NOT, 8'h03, 8'h00, 2'b10, 1, 12'h0, {8'hFC, 4'b0010});
        idle(5);
        check("drain_1", q.size(), 0);

        // Stale ALU pulse with nothing in flight is ignored.
        p0 = n_pulses;
        inject_stale = 1'b1;
        @(posedge clk); #1;
        inject_stale = 1'b0;
        idle(4);
        check("stale_ignored", n_pulses - p0, 0);

        // Reset one cycle after two transfers: nothing comes back.
        p0 = n_pulses;
        step(1, ALU_OP_OR, 8'h01, 8'h02, 0, 4'h0, 8'h00, 8'h00, 2'b01, 0, 12'h0, 12'h0);
        step(0, 4'h0, 8'h00, 8'h00, 1, ALU_OP_AND, 8'hFF, 8'hFF, 2'b10, 0, 12'h0, 12'h0);
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(5);
        check("mid_rst_no_resp", n_pulses - p0, 0);

        // Sustained contention: 0,1,0,1,0,1 with port 0 winning the first tie.
        for (int i = 0; i < 6; i++) begin
            step(1, ALU_OP_AND, 8'hA5, 8'h0F, 1, ALU_OP_NEG, 8'h01, 8'h00,
                 (i % 2 == 0) ? 2'b01 : 2'b10, 1, {8'h05, 4'b0000}, {8'hFF, 4'b0010});
        end
        idle(5);
        check("drain_2", q.size(), 0);
`ifdef W0RM_ALU_ARB_PERF_EN
        check("perf_grant0", {16'd0, perf_grant0}, 32'd3);
        check("perf_grant1", {16'd0, perf_grant1}, 32'd3);
        check("perf_conflict", {16'd0, perf_conflict}, 32'd6);
`endif

        // Opcode above NEG is forwarded; ALU returns zero.
        step(1, 4'h9, 8'h12, 8'h34, 0, 4'h0, 8'h00, 8'h00, 2'b01, 1, {8'h00, 4'b0001}, 12'h0);
        check("issue_opcode_hi", {28'd0, alu_opcode}, 32'h9);
        check("issue_operands_hi", {16'd0, alu_data_a, alu_data_b}, 32'h0000_1234);
        idle(5);
        check("drain_final", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
